apr_fm_parity_chk: RTL and testbench
====================================

// Module: apr_fm_parity_chk
// PURPOSE
// - Checks fast-memory (FM/AC) parity for the EBOX.
// - Each EDP slice drives a parity bit for its 6 data bits; this block sees six of them.
// - On an FM write it stores the six slice parities per word. On an FM read it compares
//   stored parity against the parity the EDP boards generate from the read data.
// - A mismatch latches an error with address and slice mask for APR error logic and diagnostics.
// PARAMETERS
// - BLOCKS   8   FM blocks (apr_fm_block_1/2/4)
// - ACS      16  ACs per block (apr_fm_adr_1/2/4/10)
// - SLICES   6   parity slices, 00to05 .. 30to35
// PORTS
// - clk_apr_h               in   1  APR clock; all state changes on its rising edge
// - mr_reset_h              in   1  master reset, synchronous, active-high
// - apr_fm_block_h          in   3  FM block select; [0]=block_1, [1]=block_2, [2]=block_4
// - apr_fm_adr_h            in   4  AC select; [0]=adr_1, [1]=adr_2, [2]=adr_4, [3]=adr_10
// - con_fm_write_00to17_l   in   1  active-low write strobe, left half (slices 0-2)
// - con_fm_write_18to35_l   in   1  active-low write strobe, right half (slices 3-5)
// - apr_fm_read_h           in   1  FM read this cycle (address valid)
// - edp_fm_parity_h         in   6  slice parities from the EDP boards; [k] = slice k
// - apr_fm_par_chk_en_h     in   1  enables error setting
// - diag_fm_force_bad_h     in   1  inverts parity stored on writes (diagnostic)
// - apr_fm_err_clr_h        in   1  clears error state
// - apr_fm_parity_err_h     out  1  sticky parity error
// - apr_fm_err_multi_h      out  1  another error occurred while apr_fm_parity_err_h was set
// - apr_fm_err_adr_h        out  7  {block,adr} of the first failing read
// - apr_fm_err_slice_h      out  6  mismatching slices of the first failing read
// BEHAVIOUR
// Address and storage
// - Word index idx = {apr_fm_block_h, apr_fm_adr_h}, 0..127.
// - Parity store is 128 x 6 and is not reset. A 128-bit valid vector is per half:
//   vL[idx] covers slices 0-2, vR[idx] covers slices 3-5.
// - mr_reset_h clears both valid vectors, every output, and the read pipeline.
// Writes
// - A cycle with con_fm_write_00to17_l=0 stores edp_fm_parity_h[2:0] ^ {3{force}} and sets vL[idx].
// - A cycle with con_fm_write_18to35_l=0 does the same for [5:3] and sets vR[idx].
// - Both strobes in the same cycle write both halves.
// Reads: two-stage, latency 1
// - Cycle N, apr_fm_read_h=1: register idx, the stored parity and the valid mask.
// - Same-address bypass: if a write to idx occurs in cycle N, the registered values are
//   the newly written ones.
// - Cycle N+1: mismatch[k] = valid_k & (stored[k] ^ edp_fm_parity_h[k]).
// - Unwritten (invalid) halves never produce a mismatch.
// - Back-to-back reads are fully pipelined, one per cycle.
// Error latch
// - Any mismatch with apr_fm_par_chk_en_h=1 while the error is clear: set apr_fm_parity_err_h,
//   capture apr_fm_err_adr_h and apr_fm_err_slice_h. Visible in cycle N+2.
// - Any mismatch while the error is already set: set apr_fm_err_multi_h; captured fields
//   are unchanged.
// - apr_fm_err_clr_h zeroes all four outputs.
// - Clear and a new mismatch in the same cycle: the new error is captured as first;
//   multi stays 0.
// - apr_fm_par_chk_en_h=0 suppresses setting only; the latch holds.
// Reset mid-operation
// - A read in flight at mr_reset_h is discarded. No error results in the cycle after reset.
// TESTING
// - Reset, then write idx 5 (both halves) with parity 6'b101010; read idx 5 and drive
//   6'b101010 next cycle -> err stays 0.
// - Same write and read, but drive 6'b101011 -> err=1 at N+2, adr=7'd5, slice=6'b000001.
// - Write only the 18to35 half at idx 127 with 6'b111000; read with 6'b000111 ->
//   slice=6'b111000 (left half invalid, ignored).
// - diag_fm_force_bad_h=1 during the write of idx 0x40 (6'b000000); read with 6'b000000 ->
//   err=1, slice=6'b111111.
// - Error set at idx 3; second mismatch at idx 9 -> multi=1, adr stays 3. Then clr and a
//   mismatch at idx 9 together -> err=1, adr=9, multi=0.
// - Write/read same idx in one cycle, plus a read in flight at mr_reset_h -> bypass value
//   compared; no error after reset; valid cleared, so a re-read gives no error.

Source files
------------

// File: rtl/apr_fm_parity_chk_if.sv
// FM parity checker port bundle: address, strobes and EDP parity in; error latch out.
interface apr_fm_parity_chk_if;
  logic [2:0] apr_fm_block_h;
  logic [3:0] apr_fm_adr_h;
  logic       con_fm_write_00to17_l;
  logic       con_fm_write_18to35_l;
  logic       apr_fm_read_h;
  logic [5:0] edp_fm_parity_h;
  logic       apr_fm_par_chk_en_h;
  logic       diag_fm_force_bad_h;
  logic       apr_fm_err_clr_h;
  logic       apr_fm_parity_err_h;
  logic       apr_fm_err_multi_h;
  logic [6:0] apr_fm_err_adr_h;
  logic [5:0] apr_fm_err_slice_h;

  modport master (
    output apr_fm_block_h, apr_fm_adr_h, con_fm_write_00to17_l, con_fm_write_18to35_l,
           apr_fm_read_h, edp_fm_parity_h, apr_fm_par_chk_en_h, diag_fm_force_bad_h,
           apr_fm_err_clr_h,
    input  apr_fm_parity_err_h, apr_fm_err_multi_h, apr_fm_err_adr_h, apr_fm_err_slice_h
  );

  modport slave (
    input  apr_fm_block_h, apr_fm_adr_h, con_fm_write_00to17_l, con_fm_write_18to35_l,
           apr_fm_read_h, edp_fm_parity_h, apr_fm_par_chk_en_h, diag_fm_force_bad_h,
           apr_fm_err_clr_h,
    output apr_fm_parity_err_h, apr_fm_err_multi_h, apr_fm_err_adr_h, apr_fm_err_slice_h
  );
endinterface

// File: rtl/apr_fm_parity_chk.sv
// Fast-memory parity store and checker: per-word slice parity captured on writes,
// compared against EDP-generated parity one cycle after each read.
module apr_fm_parity_chk (
  input logic                clk_apr_h,
  input logic                mr_reset_h,
  apr_fm_parity_chk_if.slave fm
);
  localparam int unsigned BLOCKS = 8;
  localparam int unsigned ACS    = 16;
  localparam int unsigned SLICES = 6;
  localparam int unsigned HALF   = SLICES / 2;
  localparam int unsigned WORDS  = BLOCKS * ACS;
  localparam int unsigned IDX_W  = $clog2(WORDS);

  logic [IDX_W-1:0]  idx_c;
  logic              wr_l_c;
  logic              wr_r_c;
  logic [SLICES-1:0] wdata_c;
  logic [SLICES-1:0] rd_par_c;
  logic [SLICES-1:0] rd_mask_c;
  logic [SLICES-1:0] mismatch_c;
  logic              hit_c;

  logic [SLICES-1:0] par_mem [WORDS];
  logic [WORDS-1:0]  vl_q;
  logic [WORDS-1:0]  vr_q;

  logic              rd_vld_q;
  logic [IDX_W-1:0]  rd_idx_q;
  logic [SLICES-1:0] rd_par_q;
  logic [SLICES-1:0] rd_mask_q;

  logic              err_q;
  logic              multi_q;
  logic [IDX_W-1:0]  adr_q;
  logic [SLICES-1:0] slice_q;

  assign idx_c   = {fm.apr_fm_block_h, fm.apr_fm_adr_h};
  assign wr_l_c  = ~fm.con_fm_write_00to17_l;
  assign wr_r_c  = ~fm.con_fm_write_18to35_l;
  assign wdata_c = fm.edp_fm_parity_h ^ {SLICES{fm.diag_fm_force_bad_h}};

  // Parity store itself is never reset; the valid vectors gate its use.
  always_ff @(posedge clk_apr_h) begin
    if (wr_l_c) par_mem[idx_c][HALF-1:0]      <= wdata_c[HALF-1:0];
    if (wr_r_c) par_mem[idx_c][SLICES-1:HALF] <= wdata_c[SLICES-1:HALF];
  end

  // Read lookup with same-cycle write bypass.
  always_comb begin
    rd_par_c  = par_mem[idx_c];
    rd_mask_c = {{HALF{vr_q[idx_c]}}, {HALF{vl_q[idx_c]}}};
    if (wr_l_c) begin
      rd_par_c[HALF-1:0]  = wdata_c[HALF-1:0];
      rd_mask_c[HALF-1:0] = '1;
    end
    if (wr_r_c) begin
      rd_par_c[SLICES-1:HALF]  = wdata_c[SLICES-1:HALF];
      rd_mask_c[SLICES-1:HALF] = '1;
    end
  end

  assign mismatch_c = rd_vld_q ? (rd_mask_q & (rd_par_q ^ fm.edp_fm_parity_h)) : '0;
  assign hit_c      = (|mismatch_c) & fm.apr_fm_par_chk_en_h;

  always_ff @(posedge clk_apr_h) begin
    if (mr_reset_h) begin
      vl_q      <= '0;
      vr_q      <= '0;
      rd_vld_q  <= 1'b0;
      rd_idx_q  <= '0;
      rd_par_q  <= '0;
      rd_mask_q <= '0;
    end else begin
      if (wr_l_c) vl_q[idx_c] <= 1'b1;
      if (wr_r_c) vr_q[idx_c] <= 1'b1;
      rd_vld_q <= fm.apr_fm_read_h;
      if (fm.apr_fm_read_h) begin
        rd_idx_q  <= idx_c;
        rd_par_q  <= rd_par_c;
        rd_mask_q <= rd_mask_c;
      end
    end
  end

  // Error latch: a clear in the same cycle as a new mismatch records it as first.
  always_ff @(posedge clk_apr_h) begin
    if (mr_reset_h) begin
      err_q   <= 1'b0;
      multi_q <= 1'b0;
      adr_q   <= '0;
      slice_q <= '0;
    end else if (fm.apr_fm_err_clr_h) begin
      err_q   <= hit_c;
      multi_q <= 1'b0;
      adr_q   <= hit_c ? rd_idx_q : '0;
      slice_q <= hit_c ? mismatch_c : '0;
    end else if (hit_c) begin
      if (err_q) begin
        multi_q <= 1'b1;
      end else begin
        err_q   <= 1'b1;
        adr_q   <= rd_idx_q;
        slice_q <= mismatch_c;
      end
    end
  end

  assign fm.apr_fm_parity_err_h = err_q;
  assign fm.apr_fm_err_multi_h  = multi_q;
  assign fm.apr_fm_err_adr_h    = adr_q;
  assign fm.apr_fm_err_slice_h  = slice_q;
endmodule

// File: tb/tb_apr_fm_parity_chk.sv
// Bench for apr_fm_parity_chk: directed scenarios then random traffic, scored against
// a behavioural model of the parity store and error latch.
module tb_apr_fm_parity_chk;
  typedef struct packed {
    logic       err;
    logic       multi;
    logic [6:0] adr;
    logic [5:0] slice;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  apr_fm_parity_chk_if fm ();

  apr_fm_parity_chk dut (
    .clk_apr_h  (clk),
    .mr_reset_h (rst),
    .fm         (fm)
  );

  always #5 clk = ~clk;

  int   n_vec = 0;
  int   n_bad = 0;
  exp_t sb[$];
  bit   drv_done = 0;

  // stimulus for one cycle
  bit       s_rst, s_wl, s_wr, s_rd, s_en, s_force, s_clr;
  int       s_idx;
  bit [5:0] s_par;

  // reference model
  bit [5:0] m_store [128];
  bit       m_vl [128];
  bit       m_vr [128];
  bit       m_pend;
  int       m_pidx;
  bit [5:0] m_ppar;
  bit [5:0] m_pmask;
  exp_t     m_out;

  task automatic model_step();
    bit [5:0] mm;
    bit       hit;
    mm = '0;
    if (m_pend)
      for (int k = 0; k < 6; k++) mm[k] = m_pmask[k] && (m_ppar[k] != s_par[k]);
    hit = m_pend && (mm != 0) && s_en;
    for (int k = 0; k < 6; k++) begin
      if ((k < 3 && s_wl) || (k >= 3 && s_wr)) m_store[s_idx][k] = s_par[k] ^ s_force;
    end
    if (s_rst) begin
      for (int i = 0; i < 128; i++) begin
        m_vl[i] = 0;
        m_vr[i] = 0;
      end
      m_pend = 0;
      m_out  = '0;
    end else begin
      if (s_clr) begin
        m_out = '0;
        if (hit) begin
          m_out.err   = 1;
          m_out.adr   = 7'(m_pidx);
          m_out.slice = mm;
        end
      end else if (hit) begin
        if (m_out.err) m_out.multi = 1;
        else begin
          m_out.err   = 1;
          m_out.adr   = 7'(m_pidx);
          m_out.slice = mm;
        end
      end
      if (s_wl) m_vl[s_idx] = 1;
      if (s_wr) m_vr[s_idx] = 1;
      m_pend = s_rd;
      if (s_rd) begin
        m_pidx  = s_idx;
        m_ppar  = m_store[s_idx];
        m_pmask = {{3{m_vr[s_idx]}}, {3{m_vl[s_idx]}}};
      end
    end
  endtask

  task automatic idle();
    s_rst = 0; s_wl = 0; s_wr = 0; s_rd = 0; s_en = 1; s_force = 0; s_clr = 0;
    s_par = '0;
  endtask

  // drive one cycle from a negedge, predict post-edge outputs, wait for next negedge
  task automatic step();
    rst                      = s_rst;
    fm.apr_fm_block_h        = 3'(s_idx >> 4);
    fm.apr_fm_adr_h          = 4'(s_idx);
    fm.con_fm_write_00to17_l = ~s_wl;
    fm.con_fm_write_18to35_l = ~s_wr;
    fm.apr_fm_read_h         = s_rd;
    fm.edp_fm_parity_h       = s_par;
    fm.apr_fm_par_chk_en_h   = s_en;
    fm.diag_fm_force_bad_h   = s_force;
    fm.apr_fm_err_clr_h      = s_clr;
    model_step();
    sb.push_back(m_out);
    @(negedge clk);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wr(input int idx, input bit l, input bit r, input bit [5:0] p, input bit f);
    idle(); s_idx = idx; s_wl = l; s_wr = r; s_par = p; s_force = f; step();
  endtask

  task automatic rd_then(input int idx, input bit [5:0] p, input bit clr);
    idle(); s_idx = idx; s_rd = 1; step();
    idle(); s_par = p; s_clr = clr; step();
  endtask

  // monitor: every cycle the DUT presents its latch state; compare with the queued prediction
  initial begin
    exp_t e, a;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() != 0) begin
        e = sb.pop_front();
        a = {fm.apr_fm_parity_err_h, fm.apr_fm_err_multi_h,
             fm.apr_fm_err_adr_h, fm.apr_fm_err_slice_h};
        n_vec++;
        if (a !== e) begin
          n_bad++;
          $display("FAIL scoreboard @%0t: got err=%0b multi=%0b adr=%0d slice=%b, expected err=%0b multi=%0b adr=%0d slice=%b",
                   $time, a.err, a.multi, a.adr, a.slice, e.err, e.multi, e.adr, e.slice);
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    idle(); s_idx = 0;
    m_out = '0; m_pend = 0;
    @(negedge clk);
    s_rst = 1; step();
    chk("reset_err", 32'(fm.apr_fm_parity_err_h), 32'd0);

    // matching parity
    wr(5, 1, 1, 6'b101010, 0);
    rd_then(5, 6'b101010, 0);
    chk("match_err", 32'(fm.apr_fm_parity_err_h), 32'd0);

    // single-slice mismatch
    wr(5, 1, 1, 6'b101010, 0);
    rd_then(5, 6'b101011, 0);
    chk("mm_err", 32'(fm.apr_fm_parity_err_h), 32'd1);
    chk("mm_adr", 32'(fm.apr_fm_err_adr_h), 32'd5);
    chk("mm_slice", 32'(fm.apr_fm_err_slice_h), 32'b000001);
    idle(); s_clr = 1; step();

    // right half only; left half invalid
    wr(127, 0, 1, 6'b111000, 0);
    rd_then(127, 6'b000111, 0);
    chk("half_slice", 32'(fm.apr_fm_err_slice_h), 32'b111000);
    chk("half_adr", 32'(fm.apr_fm_err_adr_h), 32'd127);
    idle(); s_clr = 1; step();

    // forced bad parity
    wr(7'h40, 1, 1, 6'b000000, 1);
    rd_then(7'h40, 6'b000000, 0);
    chk("force_slice", 32'(fm.apr_fm_err_slice_h), 32'b111111);
    idle(); s_clr = 1; step();

    // first error, multi, then clear+mismatch
    wr(3, 1, 1, 6'b000000, 0);
    wr(9, 1, 1, 6'b000000, 0);
    rd_then(3, 6'b000001, 0);
    chk("first_adr", 32'(fm.apr_fm_err_adr_h), 32'd3);
    rd_then(9, 6'b000001, 0);
    chk("multi_set", 32'(fm.apr_fm_err_multi_h), 32'd1);
    chk("multi_adr", 32'(fm.apr_fm_err_adr_h), 32'd3);
    rd_then(9, 6'b000001, 1);
    chk("clr_err", 32'(fm.apr_fm_parity_err_h), 32'd1);
    chk("clr_adr", 32'(fm.apr_fm_err_adr_h), 32'd9);
    chk("clr_multi", 32'(fm.apr_fm_err_multi_h), 32'd0);
    idle(); s_clr = 1; step();

    // bypass, reset with read in flight, re-read after reset
    wr(20, 1, 1, 6'b111111, 0);
    idle(); s_idx = 20; s_wl = 1; s_wr = 1; s_rd = 1; s_par = 6'b010101; step();
    idle(); s_par = 6'b010101; step();
    chk("bypass_err", 32'(fm.apr_fm_parity_err_h), 32'd0);
    idle(); s_idx = 20; s_rd = 1; step();
    idle(); s_rst = 1; s_par = 6'b000000; step();
    chk("rst_err", 32'(fm.apr_fm_parity_err_h), 32'd0);
    idle(); s_par = 6'b000000; step();
    chk("post_rst_err", 32'(fm.apr_fm_parity_err_h), 32'd0);
    rd_then(20, 6'b000000, 0);
    chk("reread_err", 32'(fm.apr_fm_parity_err_h), 32'd0);

    // random traffic over a small address window
    for (int i = 0; i < 2000; i++) begin
      s_rst   = ($urandom_range(0, 199) == 0);
      s_idx   = int'({3'($urandom_range(0, 7)), 4'($urandom_range(0, 1))});
      s_wl    = ($urandom_range(0, 2) == 0);
      s_wr    = ($urandom_range(0, 2) == 0);
      s_rd    = ($urandom_range(0, 1) == 0);
      s_par   = 6'($urandom);
      s_en    = ($urandom_range(0, 7) != 0);
      s_force = ($urandom_range(0, 15) == 0);
      s_clr   = ($urandom_range(0, 19) == 0);
      step();
    end
    idle(); step();
    drv_done = 1;
    repeat (3) @(posedge clk);
    #2;
    n_vec++;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d queued expectations, expected 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
